// File: rtl/regfile_pkg.sv
// Shared widths and grant encodings for the register-file write-back path.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the side that wins the next contention.
module rr_arbiter2
  import regfile_pkg::*;
#(
  parameter int unsigned RR_INIT = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  gnt_e ptr_q, ptr_d;

  always_comb begin
    gnt_o = req_i;
    ptr_d = ptr_q;
    // Pointer only moves on contention, so solo grants never disturb fairness.
    if (&req_i) begin
      if (ptr_q == GNT_ALU) begin
        gnt_o = 2'b01;
        ptr_d = GNT_MEM;
      end else begin
        gnt_o = 2'b10;
        ptr_d = GNT_ALU;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= (RR_INIT != 0) ? GNT_MEM : GNT_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: arbitrates ALU/MEM onto the regfile write port and
// keeps a scoreboard of destination registers with writes outstanding.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W  = regfile_pkg::ADDR_W,
  parameter int unsigned RR_INIT = 0
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     AluValid,
  output logic                     AluReady,
  input  logic [ADDR_W-1:0]        AluAddr,
  input  logic [DATA_W-1:0]        AluData,
  input  logic                     MemValid,
  output logic                     MemReady,
  input  logic [ADDR_W-1:0]        MemAddr,
  input  logic [DATA_W-1:0]        MemData,
  input  logic                     IssueValid,
  output logic                     IssueReady,
  input  logic [ADDR_W-1:0]        IssueAddr,
  output logic [(1<<ADDR_W)-1:0]   Busy,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteRegister,
  output logic [DATA_W-1:0]        WriteData
);

  logic [1:0]              gnt;
  logic [ADDR_W-1:0]       acc_addr;
  logic [DATA_W-1:0]       acc_data;
  logic                    regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]       waddr_q, waddr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [(1<<ADDR_W)-1:0]  busy_q, busy_d;

  rr_arbiter2 #(
    .RR_INIT (RR_INIT)
  ) u_arb (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .req_i  ({MemValid, AluValid}),
    .gnt_o  (gnt)
  );

  assign AluReady   = gnt[GNT_ALU];
  assign MemReady   = gnt[GNT_MEM];
  assign IssueReady = (IssueAddr == '0) || !busy_q[IssueAddr];

  always_comb begin
    acc_addr   = gnt[GNT_MEM] ? MemAddr : AluAddr;
    acc_data   = gnt[GNT_MEM] ? MemData : AluData;
    // r0 writes are accepted but never reach the regfile.
    regwrite_d = (|gnt) && (acc_addr != '0);
    waddr_d    = (|gnt) ? acc_addr : waddr_q;
    wdata_d    = (|gnt) ? acc_data : wdata_q;
  end

  always_comb begin
    busy_d = busy_q;
    // Clear lands on the same edge the regfile commits, never earlier.
    if (regwrite_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (IssueValid && IssueReady && (IssueAddr != '0)) begin
      busy_d[IssueAddr] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = waddr_q;
  assign WriteData     = wdata_q;
  assign Busy          = busy_q;

endmodule
